// File: rtl/fp_bf16_pkg.sv
// Shared bfloat16 datapath definitions: operand classes, exception flag bit
// positions and format constants.
package fp_bf16_pkg;

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } bf16_class_e;

    localparam int unsigned FLG_OF = 0;
    localparam int unsigned FLG_UF = 1;
    localparam int unsigned FLG_NX = 2;

    localparam int          BF16_EXP_MAX = 255;
    localparam logic [15:0] BF16_QNAN    = 16'h7FC0;

endpackage

// File: rtl/bf16_round_rne.sv
// Round-to-nearest-even on an 8-bit significand with guard and sticky bits.
// carry is set when rounding overflows the significand into bit 8.
module bf16_round_rne (
    input  logic [7:0] mant,
    input  logic       guard,
    input  logic       sticky,
    output logic [6:0] frac,
    output logic       carry
);

    logic       rnd;
    logic [8:0] m9;

    always_comb begin
        rnd   = guard & (sticky | mant[0]);
        m9    = {1'b0, mant} + {8'b0, rnd};
        carry = m9[8];
        // on carry-out m9 is 9'h100, so the fraction field is already zero
        frac  = m9[6:0];
    end

endmodule

// File: rtl/bf16_mul_norm_round.sv
// bfloat16 multiply back end: normalize the raw significand product, round to
// nearest-even, resolve specials/range and pack, in a 2-stage elastic pipeline.
module bf16_mul_norm_round
    import fp_bf16_pkg::*;
#(
    parameter int          EXP_W = 10,
    parameter logic [15:0] QNAN  = BF16_QNAN
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [15:0]      in_prod,
    input  logic [1:0]       in_class,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [2:0]       out_flags
);

    localparam logic signed [EXP_W:0] EXP_OVF  = BF16_EXP_MAX[EXP_W:0];
    localparam logic signed [EXP_W:0] EXP_ZERO = '0;

    logic                    s1_valid;
    logic                    s1_sign;
    logic signed [EXP_W:0]   s1_exp;
    logic [7:0]              s1_mant;
    logic                    s1_guard;
    logic                    s1_sticky;
    bf16_class_e             s1_class;

    logic                    s1_en;
    logic                    s2_en;

    logic [6:0]              r_frac;
    logic                    r_carry;
    logic signed [EXP_W:0]   exp_r;
    logic [15:0]             nxt_result;
    logic [2:0]              nxt_flags;

    assign s2_en    = !out_valid | out_ready;
    assign s1_en    = !s1_valid | s2_en;
    assign in_ready = s1_en;

    // Stage 1: single-step normalize; exponent widened by one bit so the
    // later +1 adjustments cannot wrap.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_exp    <= '0;
            s1_mant   <= '0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
            s1_class  <= CLS_NORM;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign  <= in_sign;
                s1_class <= bf16_class_e'(in_class);
                s1_exp   <= {in_exp[EXP_W-1], in_exp} + {{EXP_W{1'b0}}, in_prod[15]};
                if (in_prod[15]) begin
                    s1_mant   <= in_prod[15:8];
                    s1_guard  <= in_prod[7];
                    s1_sticky <= |in_prod[6:0];
                end else begin
                    s1_mant   <= in_prod[14:7];
                    s1_guard  <= in_prod[6];
                    s1_sticky <= |in_prod[5:0];
                end
            end
        end
    end

    bf16_round_rne u_round (
        .mant   (s1_mant),
        .guard  (s1_guard),
        .sticky (s1_sticky),
        .frac   (r_frac),
        .carry  (r_carry)
    );

    always_comb begin
        exp_r      = s1_exp + {{EXP_W{1'b0}}, r_carry};
        nxt_result = '0;
        nxt_flags  = '0;
        if (s1_class == CLS_NAN) begin
            nxt_result = QNAN;
        end else if (s1_class == CLS_INF) begin
            nxt_result = {s1_sign, 8'hFF, 7'h00};
        end else if (s1_class == CLS_ZERO) begin
            nxt_result = {s1_sign, 15'h0000};
        end else if (exp_r >= EXP_OVF) begin
            nxt_result        = {s1_sign, 8'hFF, 7'h00};
            nxt_flags[FLG_OF] = 1'b1;
            nxt_flags[FLG_NX] = 1'b1;
        end else if (exp_r <= EXP_ZERO) begin
            nxt_result        = {s1_sign, 15'h0000};
            nxt_flags[FLG_UF] = 1'b1;
            nxt_flags[FLG_NX] = 1'b1;
        end else begin
            nxt_result        = {s1_sign, exp_r[7:0], r_frac};
            nxt_flags[FLG_NX] = s1_guard | s1_sticky;
        end
    end

    // Stage 2: output register, only reloaded when it can hand off a beat.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= nxt_result;
                out_flags  <= nxt_flags;
            end
        end
    end

endmodule

// File: doc/bf16_mul_norm_round.md
Name: bf16_mul_norm_round

Overview:
Downstream stage of the 8x8 unsigned Wallace-tree significand multiplier in the bfloat16 multiply datapath. It takes the raw 16-bit significand product together with the result sign, the pre-biased exponent sum and an operand class. It normalizes, rounds to nearest-even and handles overflow, underflow and specials. It emits a packed bfloat16 result and exception flags through a 2-stage elastic valid/ready pipeline.

Parameters:
EXP_W, 10, width of signed two's-complement in_exp (covers ea+eb-127 range -127..381)
QNAN, 16'h7FC0, canonical NaN pattern emitted for class NaN

Ports:
clk  in  1  clock, rising edge
clrn  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  stage 1 can accept
in_sign  in  1  result sign (sa ^ sb)
in_exp  in  EXP_W  biased result exponent before normalization (ea+eb-127), signed
in_prod  in  16  significand product from the multiplier
in_class  in  2  0 normal, 1 zero, 2 infinity, 3 NaN
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_result  out  16  packed bfloat16 {sign, exp[7:0], frac[6:0]}
out_flags  out  3  {inexact, underflow, overflow}

Behaviour:
- Reset (clrn low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, out_result=16'h0000, out_flags=3'b000. in_ready=1 once reset is released.
- Handshake: transfer occurs when valid&ready.
  - s2_en = !s2_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en (combinational from out_ready; no bypass of stage registers).
- Latency: exactly 2 cycles from input transfer to out_valid with out_ready held high. Throughput 1/cycle.
- Output hold: out_result and out_flags are held stable while out_valid & !out_ready. Order is strictly preserved.
- Stage 1 (normalize), registered on s1_en & in_valid:
  - If in_prod[15]: mant=in_prod[15:8], guard=in_prod[7], sticky=|in_prod[6:0], exp=in_exp+1.
  - Else: mant=in_prod[14:7], guard=in_prod[6], sticky=|in_prod[5:0], exp=in_exp.
  - Normal class with in_prod[15:14]==0 takes the else path (no further shifting); callers must not rely on that result.
  - sign and class pass through.
- Stage 2 (round and pack), registered on s2_en & s1_valid:
  - Round: rnd = guard & (sticky | mant[0]). m9 = mant + rnd (9 bits). If m9[8], then exp=exp+1 and frac=0; else frac=m9[6:0].
  - Priority order:
    1. class NaN -> QNAN, flags 0.
    2. class inf -> {sign,8'hFF,7'h0}, flags 0.
    3. class zero -> {sign,15'h0}, flags 0.
    4. Post-round exp >= 255 -> {sign,8'hFF,7'h0}, overflow=1, inexact=1.
    5. Post-round exp <= 0 -> {sign,15'h0} (flush, no subnormals), underflow=1, inexact=1.
    6. Otherwise -> {sign, exp[7:0], frac}, inexact = guard|sticky.
  - Exponent arithmetic is carried at EXP_W+1 signed bits so the +1 adjustments never wrap.
- Simultaneous accept and emit with both stages full and out_ready=1: all three advance in the same cycle with no bubble.
- Reset mid-operation: all in-flight beats are discarded. No stale output appears after clrn releases.

Decomposition:
- Package fp_bf16_pkg holds:
  - class encodings (CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN)
  - flag bit indices (FLG_OF=0, FLG_UF=1, FLG_NX=2)
  - BF16_EXP_MAX=255 and BF16_QNAN
- One combinational sub-module, bf16_round_rne (mant, guard, sticky -> frac, carry), reused later by the adder's rounding stage.

Test Plan:
- 1.5x1.5: prod=16'h9000, exp=127, sign=0, class 0 -> out_result=16'h4010, flags=000, out_valid exactly 2 cycles after accept.
- Tie cases, exp=127:
  - prod=16'h40C0 -> 16'h3F82, inexact=1 (round up to even).
  - prod=16'h4040 -> 16'h3F80, inexact=1 (tie stays even).
- Round carry-out: prod=16'h7FC0, exp=127 -> 16'h4000, inexact=1.
- Range limits:
  - prod=16'h9000, exp=254 -> 16'h7F80, flags=101.
  - prod=16'h4000, exp=0, sign=1 -> 16'h8000, flags=110.
  - class NaN -> 16'h7FC0, flags=000.
- Backpressure: 4 back-to-back beats with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, out_result stable while stalled, all 4 emerge in order with no loss or duplication.
- Reset: clrn pulsed low with both stages valid -> out_valid=0 and out_result=0 immediately (asynchronous). After release, in_ready=1 and no stale beat is output.
